// File: rtl/battery_threshold_monitor_mc.sv
`timescale 1ns/1ps
// battery_threshold_monitor_mc
// Multi-channel battery monitor. For each of NUM_CH packs it produces
// hysteresis-qualified low/healthy/full crossing pulses, a debounced
// overcharge detector and a charge-control FSM. A fault stays latched until
// software acknowledges it while the pack is no longer over.
//
// Optional build macro: BATT_MON_FAULT_CNT_EN adds a per-channel 16-bit
// saturating count of FAULT entries on port fault_count. The counts are
// cleared only by reset.
//
// Ports
//   clk               system clock
//   reset             asynchronous active-low reset
//   sample_valid      per-channel sample strobe
//   battery_level     packed levels, channel i at [i*LEVEL_W +: LEVEL_W]
//   voltage           packed voltages, same packing
//   fault_clear       per-channel fault acknowledge
//   pulse_low         one-cycle low crossing pulse
//   pulse_healthy     one-cycle healthy crossing pulse
//   pulse_full        one-cycle full crossing pulse
//   charge_en         charger enable
//   overcharge_alert  high while the channel is in FAULT
//   state_out         2-bit FSM state per channel
//   any_alert         OR of overcharge_alert
//   fault_count       (BATT_MON_FAULT_CNT_EN only) 16 bits per channel
//
// state  | meaning
// CHARGE | charger enabled, waiting for full level
// FULL   | charger off, waiting for level to drop by HYST
// FAULT  | overcharge latched, charger off, waits for fault_clear

module battery_threshold_monitor_mc #(
   parameter int NUM_CH        = 4,
   parameter int LEVEL_W       = 8,
   parameter int VOLT_W        = 8,
   parameter int LOW_LEVEL     = 20,
   parameter int HEALTHY_LEVEL = 80,
   parameter int FULL_LEVEL    = 100,
   parameter int MAX_VOLTAGE   = 240,
   parameter int HYST          = 2,
   parameter int DEBOUNCE      = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           sample_valid,
   input  logic [NUM_CH*LEVEL_W-1:0]   battery_level,
   input  logic [NUM_CH*VOLT_W-1:0]    voltage,
   input  logic [NUM_CH-1:0]           fault_clear,
   output logic [NUM_CH-1:0]           pulse_low,
   output logic [NUM_CH-1:0]           pulse_healthy,
   output logic [NUM_CH-1:0]           pulse_full,
   output logic [NUM_CH-1:0]           charge_en,
   output logic [NUM_CH-1:0]           overcharge_alert,
   output logic [NUM_CH*2-1:0]         state_out,
   output logic                        any_alert
`ifdef BATT_MON_FAULT_CNT_EN
   ,
   output logic [NUM_CH*16-1:0]        fault_count
`endif
);

   typedef enum logic [1:0] {
      ST_CHARGE = 2'b00,
      ST_FULL   = 2'b01,
      ST_FAULT  = 2'b10
   } state_t;

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   localparam logic [LEVEL_W-1:0] LOW_LVL    = LEVEL_W'(LOW_LEVEL);
   localparam logic [LEVEL_W-1:0] LOW_REARM  = LEVEL_W'(LOW_LEVEL + HYST);
   localparam logic [LEVEL_W-1:0] HLT_LVL    = LEVEL_W'(HEALTHY_LEVEL);
   localparam logic [LEVEL_W-1:0] HLT_REARM  = LEVEL_W'(HEALTHY_LEVEL - HYST);
   localparam logic [LEVEL_W-1:0] FULL_LVL   = LEVEL_W'(FULL_LEVEL);
   localparam logic [LEVEL_W-1:0] FULL_REARM = LEVEL_W'(FULL_LEVEL - HYST);
   localparam logic [VOLT_W-1:0]  MAX_V      = VOLT_W'(MAX_VOLTAGE);
   localparam logic [CNT_W-1:0]   DEB_MAX    = CNT_W'(DEBOUNCE);

   // Elaboration-time parameter legality
   if (!(LOW_LEVEL + HYST < HEALTHY_LEVEL - HYST)) begin : g_err_low_hlt
      $error("LOW_LEVEL+HYST must be below HEALTHY_LEVEL-HYST");
   end
   if (!(HEALTHY_LEVEL < FULL_LEVEL)) begin : g_err_hlt_full
      $error("HEALTHY_LEVEL must be below FULL_LEVEL");
   end
   if (!(FULL_LEVEL + HYST < (2 ** LEVEL_W))) begin : g_err_width
      $error("FULL_LEVEL+HYST must fit in LEVEL_W");
   end
   if (DEBOUNCE < 1) begin : g_err_deb
      $error("DEBOUNCE must be at least 1");
   end

   logic [LEVEL_W-1:0] lvl  [NUM_CH];
   logic [VOLT_W-1:0]  volt [NUM_CH];
   logic [NUM_CH-1:0]  over;

   state_t             state_q [NUM_CH];
   state_t             state_d [NUM_CH];
   logic [CNT_W-1:0]   cnt_q   [NUM_CH];
   logic [CNT_W-1:0]   cnt_d   [NUM_CH];
   logic [NUM_CH-1:0]  low_arm_q, low_arm_d;
   logic [NUM_CH-1:0]  hlt_arm_q, hlt_arm_d;
   logic [NUM_CH-1:0]  full_arm_q, full_arm_d;
   logic [NUM_CH-1:0]  first_q, first_d;
   logic [NUM_CH-1:0]  over_now_q, over_now_d;
   logic [NUM_CH-1:0]  pulse_low_q, pulse_low_d;
   logic [NUM_CH-1:0]  pulse_hlt_q, pulse_hlt_d;
   logic [NUM_CH-1:0]  pulse_full_q, pulse_full_d;
   logic [NUM_CH-1:0]  charge_en_q, charge_en_d;
   logic [NUM_CH-1:0]  alert_q, alert_d;
   logic [NUM_CH-1:0]  fault_entry;
`ifdef BATT_MON_FAULT_CNT_EN
   logic [15:0]        fcnt_q [NUM_CH];
   logic [15:0]        fcnt_d [NUM_CH];
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign lvl[g]  = battery_level[g*LEVEL_W +: LEVEL_W];
      assign volt[g] = voltage[g*VOLT_W +: VOLT_W];
      assign over[g] = (lvl[g] > FULL_LVL) || (volt[g] > MAX_V);
      assign state_out[g*2 +: 2] = state_q[g];
`ifdef BATT_MON_FAULT_CNT_EN
      assign fault_count[g*16 +: 16] = fcnt_q[g];
`endif
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      low_arm_d    = low_arm_q;
      hlt_arm_d    = hlt_arm_q;
      full_arm_d   = full_arm_q;
      first_d      = first_q;
      over_now_d   = over_now_q;
      pulse_low_d  = '0;
      pulse_hlt_d  = '0;
      pulse_full_d = '0;
      fault_entry  = '0;
`ifdef BATT_MON_FAULT_CNT_EN
      fcnt_d       = fcnt_q;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (sample_valid[i]) begin
            over_now_d[i] = over[i];
            if (over[i]) begin
               cnt_d[i] = (cnt_q[i] == DEB_MAX) ? DEB_MAX : cnt_q[i] + CNT_W'(1);
            end else begin
               cnt_d[i] = '0;
            end
            fault_entry[i] = over[i] && (cnt_d[i] == DEB_MAX);

            if (first_q[i]) begin
               // First sample only seeds the arm flags so power-up never pulses.
               low_arm_d[i]  = (lvl[i] >= LOW_REARM);
               hlt_arm_d[i]  = (lvl[i] <= HLT_REARM);
               full_arm_d[i] = (lvl[i] <= FULL_REARM);
               first_d[i]    = 1'b0;
            end else begin
               if (low_arm_q[i] && (lvl[i] <= LOW_LVL)) begin
                  pulse_low_d[i] = 1'b1;
                  low_arm_d[i]   = 1'b0;
               end else if (lvl[i] >= LOW_REARM) begin
                  low_arm_d[i]   = 1'b1;
               end
               if (hlt_arm_q[i] && (lvl[i] >= HLT_LVL)) begin
                  pulse_hlt_d[i] = 1'b1;
                  hlt_arm_d[i]   = 1'b0;
               end else if (lvl[i] <= HLT_REARM) begin
                  hlt_arm_d[i]   = 1'b1;
               end
               if (full_arm_q[i] && (lvl[i] >= FULL_LVL) && !over[i]) begin
                  pulse_full_d[i] = 1'b1;
                  full_arm_d[i]   = 1'b0;
               end else if (lvl[i] <= FULL_REARM) begin
                  full_arm_d[i]   = 1'b1;
               end
            end
         end

         // Fault entry beats clear; clear uses over_now updated by a same-cycle sample.
         if (fault_entry[i]) begin
            state_d[i] = ST_FAULT;
         end else if (state_q[i] == ST_FAULT) begin
            if (fault_clear[i] && !over_now_d[i]) begin
               state_d[i] = ST_CHARGE;
            end
         end else if (sample_valid[i]) begin
            case (state_q[i])
               ST_CHARGE: if ((lvl[i] >= FULL_LVL) && !over[i]) state_d[i] = ST_FULL;
               ST_FULL:   if (lvl[i] <= FULL_REARM) state_d[i] = ST_CHARGE;
               default:   ;
            endcase
         end

`ifdef BATT_MON_FAULT_CNT_EN
         if (fault_entry[i] && (state_q[i] != ST_FAULT) && (fcnt_q[i] != 16'hFFFF)) begin
            fcnt_d[i] = fcnt_q[i] + 16'd1;
         end
`endif
      end
   end

   always_comb begin
      charge_en_d = '0;
      alert_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         charge_en_d[i] = (state_d[i] == ST_CHARGE);
         alert_d[i]     = (state_d[i] == ST_FAULT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_CHARGE;
            cnt_q[i]   <= '0;
`ifdef BATT_MON_FAULT_CNT_EN
            fcnt_q[i]  <= '0;
`endif
         end
         low_arm_q    <= '0;
         hlt_arm_q    <= '0;
         full_arm_q   <= '0;
         first_q      <= '1;
         over_now_q   <= '0;
         pulse_low_q  <= '0;
         pulse_hlt_q  <= '0;
         pulse_full_q <= '0;
         charge_en_q  <= '1;
         alert_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
`ifdef BATT_MON_FAULT_CNT_EN
         fcnt_q       <= fcnt_d;
`endif
         low_arm_q    <= low_arm_d;
         hlt_arm_q    <= hlt_arm_d;
         full_arm_q   <= full_arm_d;
         first_q      <= first_d;
         over_now_q   <= over_now_d;
         pulse_low_q  <= pulse_low_d;
         pulse_hlt_q  <= pulse_hlt_d;
         pulse_full_q <= pulse_full_d;
         charge_en_q  <= charge_en_d;
         alert_q      <= alert_d;
      end
   end

   assign pulse_low        = pulse_low_q;
   assign pulse_healthy    = pulse_hlt_q;
   assign pulse_full       = pulse_full_q;
   assign charge_en        = charge_en_q;
   assign overcharge_alert = alert_q;
   assign any_alert        = |alert_q;

endmodule

// File: tb/tb_battery_threshold_monitor_mc.sv
`timescale 1ns/1ps
// Directed bench for battery_threshold_monitor_mc with default parameters.
// Expected outputs are queued when a step is driven and compared one clock
// later when the registered outputs appear.

module tb_battery_threshold_monitor_mc;

   localparam logic [1:0] CG = 2'b00;
   localparam logic [1:0] FL = 2'b01;
   localparam logic [1:0] FA = 2'b10;

   logic        clk;
   logic        reset;
   logic [3:0]  sample_valid;
   logic [31:0] battery_level;
   logic [31:0] voltage;
   logic [3:0]  fault_clear;
   logic [3:0]  pulse_low, pulse_healthy, pulse_full, charge_en, overcharge_alert;
   logic [7:0]  state_out;
   logic        any_alert;
`ifdef BATT_MON_FAULT_CNT_EN
   logic [63:0] fault_count;
`endif

   battery_threshold_monitor_mc dut (
      .clk              (clk),
      .reset            (reset),
      .sample_valid     (sample_valid),
      .battery_level    (battery_level),
      .voltage          (voltage),
      .fault_clear      (fault_clear),
      .pulse_low        (pulse_low),
      .pulse_healthy    (pulse_healthy),
      .pulse_full       (pulse_full),
      .charge_en        (charge_en),
      .overcharge_alert (overcharge_alert),
      .state_out        (state_out),
      .any_alert        (any_alert)
`ifdef BATT_MON_FAULT_CNT_EN
      ,
      .fault_count      (fault_count)
`endif
   );

   typedef struct {
      string       tag;
      logic [3:0]  pl;
      logic [3:0]  ph;
      logic [3:0]  pf;
      logic [7:0]  st;
      logic [63:0] fc;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] est [4];
   int         efc [4];
   int         tests = 0;
   int         fails = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   task automatic push_exp(input string tag, input logic [3:0] pl,
                           input logic [3:0] ph, input logic [3:0] pf);
      exp_t e;
      e.tag = tag;
      e.pl  = pl;
      e.ph  = ph;
      e.pf  = pf;
      e.st  = {est[3], est[2], est[1], est[0]};
      e.fc  = {16'(efc[3]), 16'(efc[2]), 16'(efc[1]), 16'(efc[0])};
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t       e;
      logic [3:0] ce;
      logic [3:0] al;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty observed=0 entries expected=1");
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         ce[i] = (e.st[i*2 +: 2] == CG);
         al[i] = (e.st[i*2 +: 2] == FA);
      end
      tests++;
      assert (pulse_low === e.pl) else begin
         fails++;
         $error("FAIL %s pulse_low observed=%b expected=%b", e.tag, pulse_low, e.pl);
      end
      tests++;
      assert (pulse_healthy === e.ph) else begin
         fails++;
         $error("FAIL %s pulse_healthy observed=%b expected=%b", e.tag, pulse_healthy, e.ph);
      end
      tests++;
      assert (pulse_full === e.pf) else begin
         fails++;
         $error("FAIL %s pulse_full observed=%b expected=%b", e.tag, pulse_full, e.pf);
      end
      tests++;
      assert (state_out === e.st) else begin
         fails++;
         $error("FAIL %s state_out observed=%h expected=%h", e.tag, state_out, e.st);
      end
      tests++;
      assert (charge_en === ce) else begin
         fails++;
         $error("FAIL %s charge_en observed=%b expected=%b", e.tag, charge_en, ce);
      end
      tests++;
      assert (overcharge_alert === al) else begin
         fails++;
         $error("FAIL %s overcharge_alert observed=%b expected=%b", e.tag, overcharge_alert, al);
      end
      tests++;
      assert (any_alert === (|al)) else begin
         fails++;
         $error("FAIL %s any_alert observed=%b expected=%b", e.tag, any_alert, |al);
      end
`ifdef BATT_MON_FAULT_CNT_EN
      tests++;
      assert (fault_count === e.fc) else begin
         fails++;
         $error("FAIL %s fault_count observed=%h expected=%h", e.tag, fault_count, e.fc);
      end
`endif
   endtask

   // One clock of stimulus on a single channel; all other channels idle.
   task automatic ch_step(input string tag, input int ch, input bit v,
                          input int lv, input int vt, input bit clr,
                          input bit epl, input bit eph, input bit epf,
                          input logic [1:0] nst);
      logic [3:0] ml, mh, mf;
      logic [7:0] l8, v8;
      l8 = lv[7:0];
      v8 = vt[7:0];
      sample_valid = '0;
      fault_clear  = '0;
      sample_valid[ch] = v;
      fault_clear[ch]  = clr;
      battery_level[ch*8 +: 8] = l8;
      voltage[ch*8 +: 8]       = v8;
      if (nst == FA && est[ch] != FA) efc[ch] = efc[ch] + 1;
      est[ch] = nst;
      ml = '0; mh = '0; mf = '0;
      ml[ch] = epl;
      mh[ch] = eph;
      mf[ch] = epf;
      push_exp(tag, ml, mh, mf);
      @(posedge clk);
      #1;
      sample_valid = '0;
      fault_clear  = '0;
      check();
   endtask

   initial begin
      reset         = 1'b0;
      sample_valid  = '0;
      fault_clear   = '0;
      battery_level = {4{8'd50}};
      voltage       = {4{8'd100}};
      for (int i = 0; i < 4; i++) begin
         est[i] = CG;
         efc[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      push_exp("reset", 4'b0, 4'b0, 4'b0);
      check();
      reset = 1'b1;

      // ch0 low crossing with hysteresis
      ch_step("c0_first50", 0, 1, 50, 100, 0, 0, 0, 0, CG);
      ch_step("c0_21",      0, 1, 21, 100, 0, 0, 0, 0, CG);
      ch_step("c0_20",      0, 1, 20, 100, 0, 1, 0, 0, CG);
      ch_step("c0_19",      0, 1, 19, 100, 0, 0, 0, 0, CG);
      ch_step("c0_21_noarm",0, 1, 21, 100, 0, 0, 0, 0, CG);
      ch_step("c0_22",      0, 1, 22, 100, 0, 0, 0, 0, CG);
      ch_step("c0_20_again",0, 1, 20, 100, 0, 1, 0, 0, CG);

      // ch1 healthy crossing
      ch_step("c1_first70", 1, 1, 70, 100, 0, 0, 0, 0, CG);
      ch_step("c1_80",      1, 1, 80, 100, 0, 0, 1, 0, CG);
      ch_step("c1_79",      1, 1, 79, 100, 0, 0, 0, 0, CG);
      ch_step("c1_80_noarm",1, 1, 80, 100, 0, 0, 0, 0, CG);
      ch_step("c1_78",      1, 1, 78, 100, 0, 0, 0, 0, CG);
      ch_step("c1_80_again",1, 1, 80, 100, 0, 0, 1, 0, CG);
      ch_step("idle_hold",  1, 0, 50, 100, 0, 0, 0, 0, CG);

      // ch2 full crossing and FSM, then fault entry from FULL
      ch_step("c2_first95", 2, 1, 95,  100, 0, 0, 0, 0, CG);
      ch_step("c2_100",     2, 1, 100, 100, 0, 0, 0, 1, FL);
      ch_step("c2_99",      2, 1, 99,  100, 0, 0, 0, 0, FL);
      ch_step("c2_98",      2, 1, 98,  100, 0, 0, 0, 0, CG);
      ch_step("c2_100b",    2, 1, 100, 100, 0, 0, 0, 1, FL);
      ch_step("c2_101_1",   2, 1, 101, 100, 0, 0, 0, 0, FL);
      ch_step("c2_101_2",   2, 1, 101, 100, 0, 0, 0, 0, FL);
      ch_step("c2_101_3",   2, 1, 101, 100, 0, 0, 0, 0, FA);
      ch_step("c2_clr_90",  2, 1, 90,  100, 1, 0, 0, 0, CG);

      // ch3 voltage debounce and fault clear rules
      ch_step("c3_v241_1",  3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_v241_2",  3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_v200",    3, 1, 50, 200, 0, 0, 0, 0, CG);
      ch_step("c3_v241_a",  3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_v241_b",  3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_v241_c",  3, 1, 50, 241, 0, 0, 0, 0, FA);
      ch_step("c3_clr_over",3, 1, 50, 241, 1, 0, 0, 0, FA);
      ch_step("c3_clr_nov", 3, 0, 50, 241, 1, 0, 0, 0, FA);
      ch_step("c3_v200_nc", 3, 1, 50, 200, 0, 0, 0, 0, FA);
      ch_step("c3_clr_ok",  3, 0, 50, 200, 1, 0, 0, 0, CG);

      // ch3 level over with invalid gaps between samples
      ch_step("c3_l101_1",  3, 1, 101, 100, 0, 0, 1, 0, CG);
      ch_step("c3_gap_1",   3, 0, 50,  100, 0, 0, 0, 0, CG);
      ch_step("c3_l101_2",  3, 1, 101, 100, 0, 0, 0, 0, CG);
      ch_step("c3_gap_2",   3, 0, 50,  100, 0, 0, 0, 0, CG);
      ch_step("c3_gap_3",   3, 0, 50,  100, 0, 0, 0, 0, CG);
      ch_step("c3_l101_3",  3, 1, 101, 100, 0, 0, 0, 0, FA);
      ch_step("c3_clr_same",3, 1, 50,  100, 1, 0, 0, 0, CG);

      // re-arm ch0, then fault ch3 again and reset mid-FAULT
      ch_step("c0_30_rearm",0, 1, 30, 100, 0, 0, 0, 0, CG);
      ch_step("c3_f2_1",    3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_f2_2",    3, 1, 50, 241, 0, 0, 0, 0, CG);
      ch_step("c3_f2_3",    3, 1, 50, 241, 0, 0, 0, 0, FA);

      reset = 1'b0;
      #2;
      for (int i = 0; i < 4; i++) begin
         est[i] = CG;
         efc[i] = 0;
      end
      push_exp("reset_mid_fault", 4'b0, 4'b0, 4'b0);
      check();
      @(posedge clk);
      #1;
      reset = 1'b1;

      ch_step("post_c0_first20", 0, 1, 20,  100, 0, 0, 0, 0, CG);
      ch_step("post_c0_19",      0, 1, 19,  100, 0, 0, 0, 0, CG);
      ch_step("post_c3_v241",    3, 1, 50,  241, 0, 0, 0, 0, CG);
      ch_step("post_c3_v200",    3, 1, 50,  200, 0, 0, 0, 0, CG);

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/battery_threshold_monitor_mc.md
Name: battery_threshold_monitor_mc

Overview:
Multi-channel, parametrised successor to the single-pack battery notification block. One instance serves NUM_CH packs. Per channel it provides:
- hysteresis-qualified low, healthy and full crossing pulses
- a debounced overcharge detector
- a charge-control FSM with a latched fault that software must clear

It sits between the per-pack ADC sample front end and the charger enable and interrupt logic.

Parameters:
NUM_CH, 4, number of battery channels
LEVEL_W, 8, width of each battery_level sample (percent)
VOLT_W, 8, width of each voltage sample
LOW_LEVEL, 20, low-battery warning threshold
HEALTHY_LEVEL, 80, healthy-charge threshold
FULL_LEVEL, 100, full-charge threshold
MAX_VOLTAGE, 240, overvoltage threshold; fault when voltage > MAX_VOLTAGE
HYST, 2, re-arm and recharge hysteresis in level units
DEBOUNCE, 3, consecutive over-condition samples needed to enter FAULT (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sample_valid  input  NUM_CH  per-channel sample strobe
battery_level  input  NUM_CH*LEVEL_W  packed levels; channel i at [i*LEVEL_W +: LEVEL_W]
voltage  input  NUM_CH*VOLT_W  packed voltages; same packing
fault_clear  input  NUM_CH  per-channel fault acknowledge
pulse_low  output  NUM_CH  one-cycle low-crossing pulse
pulse_healthy  output  NUM_CH  one-cycle healthy-crossing pulse
pulse_full  output  NUM_CH  one-cycle full-crossing pulse
charge_en  output  NUM_CH  charger enable
overcharge_alert  output  NUM_CH  high while the channel is in FAULT
state_out  output  NUM_CH*2  FSM state per channel
any_alert  output  1  OR of overcharge_alert

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low.
- Reset values:
  - all pulses 0, overcharge_alert 0, any_alert 0
  - charge_en all 1
  - state CHARGE (2'b00)
  - debounce counters 0, arm flags 0
  - per-channel first flag 1
- Channels are fully independent. A channel's logic acts only on cycles where sample_valid[i]=1. With no valid sample, the channel's state, arm flags and counter hold, and its pulses are 0.
- Latency: all outputs are registered and reflect a sample on the clock edge after it is presented. Pulses last exactly one cycle. any_alert is the combinational OR of the registered alerts.
- over condition: level > FULL_LEVEL or voltage > MAX_VOLTAGE.
- First valid sample after reset:
  - initialises the arm flags from the level, with no pulse
  - low armed if level >= LOW_LEVEL+HYST
  - healthy armed if level <= HEALTHY_LEVEL-HYST
  - full armed if level <= FULL_LEVEL-HYST
  - the first flag then clears
  - the FSM and debounce logic still evaluate this sample
- Crossing pulses (valid sample, first=0). Each crossing fires at most once per arm:
  - pulse_low=1 if low armed and level <= LOW_LEVEL; disarms low. Re-arms when level >= LOW_LEVEL+HYST.
  - pulse_healthy=1 if healthy armed and level >= HEALTHY_LEVEL; disarms. Re-arms when level <= HEALTHY_LEVEL-HYST.
  - pulse_full=1 if full armed and level >= FULL_LEVEL and not over; disarms. Re-arms when level <= FULL_LEVEL-HYST.
- Debounce counter, width $clog2(DEBOUNCE+1):
  - increments on each valid over sample and saturates at DEBOUNCE
  - clears on a valid non-over sample
  - an over_now flag records whether the last valid sample was over
- FSM encoding: CHARGE=00, FULL=01, FAULT=10.
  - CHARGE (charge_en=1): goes to FULL on a valid sample with level >= FULL_LEVEL and not over.
  - FULL (charge_en=0): goes to CHARGE on a valid sample with level <= FULL_LEVEL-HYST.
  - FAULT (charge_en=0, overcharge_alert=1): entered from any state when the counter reaches DEBOUNCE on the current valid sample. Exited to CHARGE on fault_clear[i]=1 only while over_now=0.
  - fault_clear while over_now=1, or outside FAULT, is ignored and not remembered.
- Same-cycle priority: fault entry > fault_clear > FULL/CHARGE transitions. Crossing pulses are still generated in FAULT.
- fault_clear and sample_valid in the same cycle: over_now is evaluated from the current sample.
- Wrap-around: none. All comparisons are unsigned at the native width, and HYST subtraction and addition are elaborated as constants.
- Parameter legality, checked at elaboration:
  - LOW_LEVEL+HYST < HEALTHY_LEVEL-HYST
  - HEALTHY_LEVEL < FULL_LEVEL
  - FULL_LEVEL+HYST fits in LEVEL_W
- Reset asserted mid-operation returns every channel to its reset values immediately, including clearing a latched FAULT.

Optional Feature:
BATT_MON_FAULT_CNT_EN
- Defined:
  - adds output fault_count, NUM_CH*16 bits
  - per-channel counter increments on every entry into FAULT (re-entry included)
  - saturates at 16'hFFFF
  - cleared only by reset; fault_clear does not affect it
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults, ch0: first sample 50, then 21, 20, 19 -> pulse_low only after the 20 sample. Then 21 -> no pulse (not re-armed). Then 22, 20 -> second pulse_low.
- ch1 samples 70, 80, 79, 80 -> pulse_healthy once. Then 78, 80 -> second pulse. ch0 and ch2 stay quiet.
- ch2 charging: 95, 100 -> pulse_full, state 01, charge_en 0. Then 99 -> stays FULL. Then 98 -> CHARGE, charge_en 1.
- ch3 voltage 241 for 2 samples then 200 -> no fault. Then 241 ×3 -> FAULT after the 3rd sample, alert 1, any_alert 1. fault_clear while 241 -> still FAULT. Sample 200 then fault_clear -> CHARGE, alert 0.
- Level 101 for 3 valid samples with invalid cycles between -> FAULT. The gaps neither reset nor advance the counter.
- With BATT_MON_FAULT_CNT_EN: two fault/clear cycles -> fault_count=2. Then reset low mid-FAULT -> state CHARGE, charge_en 1, count 0.
